// File: rtl/hyperram_target.sv
// HyperBus RAM target at word-level DDR abstraction: one clk = one CK = one 16-bit word.
// Decodes CA, applies CR0 latency, serves memory and register accesses from an internal array.
module hyperram_target #(
    parameter int          ADDR_BITS = 10,
    parameter logic [15:0] ID0_VALUE = 16'h0C81,
    parameter logic [15:0] ID1_VALUE = 16'h0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ram_reset_b,
    input  logic        cs_b,
    input  logic        ck,
    input  logic [15:0] dq_in,
    input  logic [1:0]  rwds_in,
    input  logic        refresh_req,
    output logic [15:0] dq_out,
    output logic [1:0]  rwds_out,
    output logic        dq_oe,
    output logic        rwds_oe,
    output logic [15:0] cr0
);

    localparam int AW = ADDR_BITS;

    localparam logic [2:0] R_NONE = 3'd0;
    localparam logic [2:0] R_ID0  = 3'd1;
    localparam logic [2:0] R_ID1  = 3'd2;
    localparam logic [2:0] R_CR0  = 3'd3;
    localparam logic [2:0] R_CR1  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CA,
        S_REGW,
        S_LAT,
        S_WDATA,
        S_RDATA,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [4:0]    cnt_q;
    logic [4:0]    dm1_q;
    logic [15:0]   ca_hi_q;
    logic [15:0]   ca_mid_q;
    logic [AW-1:0] start_q;
    logic [AW-1:0] k_q;
    logic [AW-1:0] wmask_q;
    logic          rd_q;
    logic          reg_q;
    logic          lin_q;
    logic          x2_q;
    logic [2:0]    rsel_q;
    logic [15:0]   cr0_q;
    logic [15:0]   cr1_q;
    logic [15:0]   dq_out_q;
    logic [1:0]    rwds_out_q;
    logic          dq_oe_q;
    logic          rwds_oe_q;

    logic [15:0]   mem [0:(1<<AW)-1];

    logic          rst;
    logic          go;
    logic [3:0]    lat;
    logic          x2_d;
    logic [4:0]    dm1_d;
    logic [AW-1:0] wmask_d;
    logic [31:0]   addr32;
    logic [31:0]   regaddr;
    logic [2:0]    rsel_d;
    logic          d_rd;
    logic          d_reg;
    logic          d_lin;
    logic [AW-1:0] lin_a;
    logic [AW-1:0] cur_a;
    logic [15:0]   regval;
    logic [15:0]   rd_word;
    logic          mem_we;

    assign rst = reset | ~ram_reset_b;
    assign go  = ~cs_b & ck;

    always_comb begin
        lat = 4'd6;
        case (cr0_q[7:4])
            4'b1110: lat = 4'd3;
            4'b1111: lat = 4'd4;
            4'b0000: lat = 4'd5;
            4'b0001: lat = 4'd6;
            4'b0010: lat = 4'd7;
            default: lat = 4'd6;
        endcase
    end

    assign x2_d  = cr0_q[3] | refresh_req;
    // dm1 is the last latency cycle index (D-1), where the first read word is fetched
    assign dm1_d = 5'd1 + (x2_d ? {lat, 1'b0} : {1'b0, lat});

    always_comb begin
        wmask_d = AW'(63);
        case (cr0_q[1:0])
            2'b00: wmask_d = AW'(63);
            2'b01: wmask_d = AW'(31);
            2'b10: wmask_d = AW'(7);
            2'b11: wmask_d = AW'(15);
            default: wmask_d = AW'(63);
        endcase
    end

    assign addr32  = {ca_hi_q[12:0], ca_mid_q, dq_in[2:0]};
    assign regaddr = addr32 & ~(32'd1 << 22);
    assign d_rd    = ca_hi_q[15];
    assign d_reg   = ca_hi_q[14];
    assign d_lin   = ca_hi_q[13];

    always_comb begin
        rsel_d = R_NONE;
        case (regaddr)
            32'h0000_0000: rsel_d = R_ID0;
            32'h0000_0001: rsel_d = R_ID1;
            32'h0000_0800: rsel_d = R_CR0;
            32'h0000_0801: rsel_d = R_CR1;
            default:       rsel_d = R_NONE;
        endcase
    end

    assign lin_a = start_q + k_q;
    assign cur_a = lin_q ? lin_a
                         : ((start_q & ~wmask_q) | (lin_a & wmask_q));

    always_comb begin
        regval = 16'h0000;
        case (rsel_q)
            R_ID0:   regval = ID0_VALUE;
            R_ID1:   regval = ID1_VALUE;
            R_CR0:   regval = cr0_q;
            R_CR1:   regval = cr1_q;
            default: regval = 16'h0000;
        endcase
    end

    assign rd_word = reg_q ? regval : mem[cur_a];
    assign mem_we  = ~rst & go & (state_q == S_WDATA);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (!rwds_in[1]) mem[cur_a][15:8] <= dq_in[15:8];
            if (!rwds_in[0]) mem[cur_a][7:0]  <= dq_in[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            dq_out_q   <= 16'h0000;
            rwds_out_q <= 2'b00;
            dq_oe_q    <= 1'b0;
            rwds_oe_q  <= 1'b0;
            cr0_q      <= 16'h8F1F;
            cr1_q      <= 16'hFFC1;
        end else if (cs_b) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            dq_oe_q    <= 1'b0;
            rwds_oe_q  <= 1'b0;
            rwds_out_q <= 2'b00;
        end else if (ck) begin
            case (state_q)
                S_IDLE: begin
                    ca_hi_q    <= dq_in;
                    x2_q       <= x2_d;
                    dm1_q      <= dm1_d;
                    wmask_q    <= wmask_d;
                    rwds_oe_q  <= 1'b1;
                    rwds_out_q <= {2{x2_d}};
                    cnt_q      <= 5'd1;
                    state_q    <= S_CA;
                end
                S_CA: begin
                    if (cnt_q == 5'd1) begin
                        ca_mid_q <= dq_in;
                        cnt_q    <= 5'd2;
                    end else begin
                        start_q <= addr32[AW-1:0];
                        rd_q    <= d_rd;
                        reg_q   <= d_reg;
                        lin_q   <= d_lin;
                        rsel_q  <= rsel_d;
                        k_q     <= '0;
                        cnt_q   <= 5'd3;
                        if (!d_rd && d_reg) begin
                            state_q   <= S_REGW;
                            rwds_oe_q <= 1'b0;
                        end else begin
                            state_q <= S_LAT;
                        end
                    end
                end
                S_LAT: begin
                    if (cnt_q == dm1_q) begin
                        if (rd_q) begin
                            state_q    <= S_RDATA;
                            dq_oe_q    <= 1'b1;
                            rwds_out_q <= 2'b10;
                            dq_out_q   <= rd_word;
                            k_q        <= k_q + AW'(1);
                        end else begin
                            state_q    <= S_WDATA;
                            rwds_oe_q  <= 1'b0;
                            rwds_out_q <= 2'b00;
                        end
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                S_RDATA: begin
                    dq_out_q <= rd_word;
                    k_q      <= k_q + AW'(1);
                end
                S_WDATA: begin
                    k_q <= k_q + AW'(1);
                end
                S_REGW: begin
                    if (rsel_q == R_CR0) cr0_q <= dq_in;
                    if (rsel_q == R_CR1) cr1_q <= dq_in;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dq_out   = dq_out_q;
    assign rwds_out = rwds_out_q;
    assign dq_oe    = dq_oe_q;
    assign rwds_oe  = rwds_oe_q;
    assign cr0      = cr0_q;

endmodule

// File: tb/tb_hyperram_target.sv
// Randomized bench for hyperram_target with a cycle-indexed behavioural model.
// Model derives expected pins from transaction parameters and cycle number.
module tb_hyperram_target;

    localparam int NW = 1024;

    logic        clk = 1'b0;
    logic        reset, ram_reset_b, cs_b, ck, refresh_req;
    logic [15:0] dq_in;
    logic [1:0]  rwds_in;
    logic [15:0] dq_out, cr0;
    logic [1:0]  rwds_out;
    logic        dq_oe, rwds_oe;

    always #5 clk = ~clk;

    hyperram_target dut (
        .clk         (clk),
        .reset       (reset),
        .ram_reset_b (ram_reset_b),
        .cs_b        (cs_b),
        .ck          (ck),
        .dq_in       (dq_in),
        .rwds_in     (rwds_in),
        .refresh_req (refresh_req),
        .dq_out      (dq_out),
        .rwds_out    (rwds_out),
        .dq_oe       (dq_oe),
        .rwds_oe     (rwds_oe),
        .cr0         (cr0)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] mem_m [0:NW-1];
    logic [15:0] cr0_m, cr1_m;
    logic [15:0] wd [0:NW-1];
    logic [1:0]  wm [0:NW-1];

    logic        chk_on = 1'b0;
    logic        e_dq_oe, e_rwds_oe, e_rwds_chk, e_new, e_dq_chk;
    logic [1:0]  e_rwds;
    logic [15:0] e_dq;
    int          e_cyc;
    int          stall_pct;

    logic [15:0] got_q [$];
    int          cyc_q [$];

    task automatic cmp(input string nm, input logic [15:0] g, input logic [15:0] e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, g, e, $time);
        end
    endtask

    function automatic int lat_of(input logic [15:0] c);
        case (c[7:4])
            4'hE: return 3;
            4'hF: return 4;
            4'h0: return 5;
            4'h1: return 6;
            4'h2: return 7;
            default: return 6;
        endcase
    endfunction

    function automatic int wbits(input logic [1:0] s);
        case (s)
            2'b00: return 6;
            2'b01: return 5;
            2'b10: return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int maddr(input int st, input bit lin, input int k, input int w);
        int msk;
        if (lin) return (st + k) % NW;
        msk = (1 << w) - 1;
        return (st & ~msk) | ((st + k) & msk);
    endfunction

    function automatic logic [15:0] regval(input logic [31:0] a);
        case (a)
            32'h000: return 16'h0C81;
            32'h001: return 16'h0001;
            32'h800: return cr0_m;
            32'h801: return cr1_m;
            default: return 16'h0000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("dq_oe", {15'd0, dq_oe}, {15'd0, e_dq_oe});
            cmp("rwds_oe", {15'd0, rwds_oe}, {15'd0, e_rwds_oe});
            cmp("cr0", cr0, cr0_m);
            if (e_rwds_chk) cmp("rwds_out", {14'd0, rwds_out}, {14'd0, e_rwds});
            if (e_dq_oe || e_dq_chk) cmp("dq_out", dq_out, e_dq);
            if (e_new) begin
                got_q.push_back(dq_out);
                cyc_q.push_back(e_cyc);
            end
        end
    end

    task automatic set_idle_exp(input bit dqchk);
        e_dq_oe    = 1'b0;
        e_rwds_oe  = 1'b0;
        e_rwds     = 2'b00;
        e_rwds_chk = 1'b1;
        e_new      = 1'b0;
        e_dq_chk   = dqchk;
        e_dq       = 16'h0000;
    endtask

    task automatic do_reset(input bit ram);
        if (ram) ram_reset_b = 1'b0;
        else reset = 1'b1;
        cs_b  = 1'b0;
        ck    = 1'b1;
        dq_in = 16'($urandom);
        repeat (2) begin
            @(posedge clk); #1;
            cr0_m = 16'h8F1F;
            cr1_m = 16'hFFC1;
            set_idle_exp(1'b1);
            chk_on = 1'b1;
        end
        reset       = 1'b0;
        ram_reset_b = 1'b1;
        cs_b        = 1'b1;
        @(posedge clk); #1;
        set_idle_exp(1'b0);
    endtask

    task automatic xact(input bit rd, input bit rg, input bit lin,
                        input logic [31:0] a, input int nw, input bit refr,
                        input int ab_at, input int ab_kind);
        logic [47:0] ca;
        logic [31:0] ra;
        int n, m, k, d, l, w, st, last, ad;
        bit x2;
        ca   = {rd, rg, lin, a[31:3], 13'd0, a[2:0]};
        ra   = a & ~32'h0040_0000;
        x2   = cr0_m[3] | refr;
        l    = lat_of(cr0_m);
        w    = wbits(cr0_m[1:0]);
        st   = int'(a[9:0]);
        d    = (!rd && rg) ? 3 : 2 + (x2 ? 2 : 1) * l;
        last = rd ? d + nw - 2 : d + nw - 1;
        n    = 0;
        while (n <= last) begin
            if (ab_at >= 0 && n == ab_at) break;
            cs_b = 1'b0;
            if (int'($urandom_range(99)) < stall_pct) begin
                ck          = 1'b0;
                dq_in       = 16'($urandom);
                rwds_in     = 2'($urandom);
                refresh_req = 1'($urandom);
                @(posedge clk); #1;
                e_new = 1'b0;
            end else begin
                ck          = 1'b1;
                refresh_req = (n == 0) ? refr : 1'($urandom);
                if (n < 3) dq_in = ca[47-16*n -: 16];
                else if (n >= d) dq_in = wd[n-d];
                else dq_in = 16'($urandom);
                rwds_in = (n >= d) ? wm[n-d] : 2'($urandom);
                @(posedge clk); #1;
                if (!rd && n >= d) begin
                    k = n - d;
                    if (rg) begin
                        if (k == 0 && ra == 32'h800) cr0_m = wd[0];
                        if (k == 0 && ra == 32'h801) cr1_m = wd[0];
                    end else begin
                        ad = maddr(st, lin, k, w);
                        if (!wm[k][1]) mem_m[ad][15:8] = wd[k][15:8];
                        if (!wm[k][0]) mem_m[ad][7:0]  = wd[k][7:0];
                    end
                end
                m = n + 1;
                e_dq_chk = 1'b0;
                if (m < d) begin
                    e_dq_oe    = 1'b0;
                    e_rwds_oe  = 1'b1;
                    e_rwds     = {2{x2}};
                    e_rwds_chk = 1'b1;
                    e_new      = 1'b0;
                end else if (rd) begin
                    k          = m - d;
                    e_dq_oe    = 1'b1;
                    e_rwds_oe  = 1'b1;
                    e_rwds     = 2'b10;
                    e_rwds_chk = 1'b1;
                    e_dq       = rg ? regval(ra) : mem_m[maddr(st, lin, k, w)];
                    e_new      = 1'b1;
                    e_cyc      = m;
                end else begin
                    e_dq_oe    = 1'b0;
                    e_rwds_oe  = 1'b0;
                    e_rwds_chk = 1'b0;
                    e_new      = 1'b0;
                end
                n++;
            end
        end
        if (ab_at >= 0 && n == ab_at && ab_kind != 0) begin
            do_reset(ab_kind == 2);
        end else begin
            cs_b  = 1'b1;
            ck    = 1'($urandom);
            dq_in = 16'($urandom);
            @(posedge clk); #1;
            set_idle_exp(1'b0);
        end
    endtask

    task automatic gotw(input string nm, input logic [15:0] ev, input int ecyc);
        int c;
        if (got_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s got=none want=%h", nm, ev);
        end else begin
            cmp(nm, got_q.pop_front(), ev);
            c = cyc_q.pop_front();
            if (ecyc >= 0) cmp({nm, "_cyc"}, 16'(c), 16'(ecyc));
        end
    endtask

    initial begin
        reset       = 1'b1;
        ram_reset_b = 1'b1;
        cs_b        = 1'b1;
        ck          = 1'b0;
        dq_in       = 16'h0;
        rwds_in     = 2'b00;
        refresh_req = 1'b0;
        stall_pct   = 0;
        set_idle_exp(1'b0);
        cr0_m = 16'h8F1F;
        cr1_m = 16'hFFC1;

        do_reset(1'b0);
        cmp("reset_cr0", cr0, 16'h8F1F);

        got_q.delete(); cyc_q.delete();
        xact(1, 1, 0, 32'h800, 1, 0, -1, 0);
        gotw("t1_cr0_read", 16'h8F1F, 14);
        xact(1, 1, 0, 32'h000, 2, 0, -1, 0);
        gotw("t1_id0", 16'h0C81, 14);
        gotw("t1_id0_again", 16'h0C81, 15);

        for (int i = 0; i < NW; i++) begin
            wd[i] = 16'($urandom);
            wm[i] = 2'b00;
        end
        xact(0, 0, 1, 32'hABC0_0000, NW, 0, -1, 0);

        wd[0] = 16'h8FE7;
        xact(0, 1, 0, 32'h800, 1, 0, -1, 0);
        cmp("t2_cr0", cr0, 16'h8FE7);
        got_q.delete(); cyc_q.delete();
        xact(1, 0, 1, 32'h40, 1, 0, -1, 0);
        gotw("t2_read", mem_m[64], 5);

        wd[0] = 16'h5AA5; wm[0] = 2'b00;
        xact(0, 0, 1, 32'h11, 1, 0, -1, 0);
        wd[0] = 16'h1234; wm[0] = 2'b00;
        wd[1] = 16'hABCD; wm[1] = 2'b10;
        xact(0, 0, 1, 32'h10, 2, 0, -1, 0);
        got_q.delete(); cyc_q.delete();
        xact(1, 0, 1, 32'h10, 2, 0, -1, 0);
        gotw("t3_w0", 16'h1234, 5);
        gotw("t3_w1", 16'h5ACD, 6);

        xact(1, 0, 1, 32'h10, 1, 1, -1, 0);
        gotw("t4_refresh", 16'h1234, 8);

        wd[0] = 16'h8FE6;
        xact(0, 1, 0, 32'h800, 1, 0, -1, 0);
        for (int i = 0; i < 8; i++) begin
            wd[i] = 16'hC000 + 16'(i);
            wm[i] = 2'b00;
        end
        xact(0, 0, 1, 32'h10, 8, 0, -1, 0);
        got_q.delete(); cyc_q.delete();
        xact(1, 0, 0, 32'h16, 8, 0, -1, 0);
        for (int i = 0; i < 8; i++)
            gotw("t5_wrap", 16'hC000 + 16'((6 + i) % 8), 5 + i);

        wd[0] = 16'h7777; wm[0] = 2'b00;
        xact(0, 0, 1, 32'h20, 1, 0, -1, 0);
        wd[0] = 16'h1111;
        xact(0, 0, 1, 32'h20, 1, 0, 5, 0);
        got_q.delete(); cyc_q.delete();
        xact(1, 0, 1, 32'h20, 1, 0, -1, 0);
        gotw("t6_abort", 16'h7777, 5);

        wd[0] = 16'h2222;
        xact(0, 0, 1, 32'h21, 1, 0, 5, 2);
        cmp("t7_cr0_after_ramreset", cr0, 16'h8F1F);
        got_q.delete(); cyc_q.delete();
        xact(1, 0, 1, 32'h21, 1, 0, -1, 0);
        gotw("t7_kept", mem_m[33], 14);

        stall_pct = 15;
        for (int t = 0; t < 80; t++) begin
            int kind, nw, ab, abk;
            logic [31:0] a;
            logic [31:0] rtab [6];
            rtab = '{32'h0, 32'h1, 32'h800, 32'h801, 32'h2, 32'h0040_0800};
            kind = $urandom_range(0, 9);
            nw   = $urandom_range(1, 10);
            ab   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : -1;
            abk  = $urandom_range(0, 2);
            for (int i = 0; i < nw; i++) begin
                wd[i] = 16'($urandom);
                wm[i] = 2'($urandom);
            end
            a = $urandom;
            if (kind <= 3)
                xact(0, 0, 1'($urandom), a, nw, 1'($urandom), ab, abk);
            else if (kind <= 6)
                xact(1, 0, 1'($urandom), a, nw, 1'($urandom), ab, abk);
            else if (kind == 7)
                xact(1, 1, 1'($urandom), rtab[$urandom_range(0, 5)], nw,
                     1'($urandom), ab, abk);
            else if (kind == 8)
                xact(0, 1, 0, rtab[$urandom_range(0, 5)], $urandom_range(1, 3),
                     1'($urandom), ab, abk);
            else
                do_reset(1'($urandom));
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
